// File: rtl/reject_sample_ctrl_if.sv
// Bundle of the control, random-word, sampler and coefficient-stream signals
// around the rejection-sampler sequencer.
interface reject_sample_ctrl_if #(
  parameter int LANES     = 4,
  parameter int CAND_BITS = 12,
  parameter int N_COEFF   = 256
);
  localparam int IW = $clog2(N_COEFF);

  logic                       start;
  logic [15:0]                q_cfg;
  logic                       busy;
  logic                       done;

  logic                       rnd_tvalid;
  logic                       rnd_tready;
  logic [LANES*CAND_BITS-1:0] rnd_tdata;

  logic                       smp_valid;
  logic [LANES*CAND_BITS-1:0] smp_cand;
  logic [15:0]                smp_q;
  logic [LANES-1:0]           smp_acc;
  logic [LANES*CAND_BITS-1:0] smp_data;

  logic                       coef_tvalid;
  logic                       coef_tready;
  logic [CAND_BITS-1:0]       coef_tdata;
  logic [IW-1:0]              coef_index;
  logic                       coef_tlast;

  modport master (
    input  start, q_cfg, rnd_tvalid, rnd_tdata, smp_acc, smp_data, coef_tready,
    output busy, done, rnd_tready, smp_valid, smp_cand, smp_q,
           coef_tvalid, coef_tdata, coef_index, coef_tlast
  );

  modport slave (
    output start, q_cfg, rnd_tvalid, rnd_tdata, smp_acc, smp_data, coef_tready,
    input  busy, done, rnd_tready, smp_valid, smp_cand, smp_q,
           coef_tvalid, coef_tdata, coef_index, coef_tlast
  );
endinterface

// File: rtl/reject_sample_ctrl.sv
// Rejection-sampler sequencer: credit-gated issue of random words, token-tracked
// sampler returns, in-order lane compaction into a coefficient FIFO.
module reject_sample_ctrl #(
  parameter int LANES      = 4,
  parameter int CAND_BITS  = 12,
  parameter int N_COEFF    = 256,
  parameter int SMP_LAT    = 3,
  parameter int FIFO_DEPTH = 16
) (
  input logic                 clk,
  input logic                 rst,
  reject_sample_ctrl_if.master bus
);
  localparam int CW = $clog2(N_COEFF) + 1;
  localparam int IW = $clog2(N_COEFF);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int FW = PW + 1;
  localparam int NW = $clog2(LANES + 1);
  localparam int TW = $clog2(SMP_LAT + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FLUSH} state_e;

  state_e                     state_q;
  logic [CW-1:0]              acc_cnt_q, acc_cnt_d;
  logic [CW-1:0]              out_cnt_q, out_cnt_d;
  logic [15:0]                q_q;
  logic                       busy_q, done_q;
  logic                       smp_valid_q;
  logic [LANES*CAND_BITS-1:0] smp_cand_q;
  logic [SMP_LAT-1:0]         tok_q;
  logic [CAND_BITS-1:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]              rd_ptr_q, wr_ptr_q;
  logic [FW-1:0]              fifo_cnt_q, fifo_cnt_d;

  logic [TW-1:0]              inflight;
  logic [FW-1:0]              fifo_free;
  logic                       issue_ok, xfer, tap, pop, fifo_nempty;
  logic [CW-1:0]              remaining;
  logic [NW-1:0]              n_wr;
  logic [LANES-1:0]           wr_en;
  logic [NW-1:0]              wr_off [LANES];

  // Credit check: every issued-but-unreturned word may still land LANES entries.
  always_comb begin
    inflight = TW'(smp_valid_q);
    for (int i = 0; i < SMP_LAT; i++) begin
      inflight = inflight + TW'(tok_q[i]);
    end
  end

  assign fifo_free   = FW'(FIFO_DEPTH) - fifo_cnt_q;
  assign issue_ok    = (state_q == RUN) &&
                       (32'(fifo_free) >= 32'(LANES) * (32'(inflight) + 32'd1)) &&
                       (acc_cnt_q < CW'(N_COEFF));
  assign xfer        = bus.rnd_tvalid & issue_ok;
  assign tap         = tok_q[SMP_LAT-1];
  assign fifo_nempty = (fifo_cnt_q != '0);
  assign pop         = fifo_nempty & bus.coef_tready;
  assign remaining   = CW'(N_COEFF) - acc_cnt_q;

  // Accepted lanes take consecutive FIFO slots in lane order, capped at the
  // number of coefficients still missing from the polynomial.
  always_comb begin
    n_wr  = '0;
    wr_en = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_off[i] = n_wr;
      if (tap && bus.smp_acc[i] && (CW'(n_wr) < remaining)) begin
        wr_en[i] = 1'b1;
        n_wr     = n_wr + NW'(1);
      end
    end
  end

  assign acc_cnt_d  = acc_cnt_q + CW'(n_wr);
  assign out_cnt_d  = out_cnt_q + CW'(pop);
  assign fifo_cnt_d = fifo_cnt_q + FW'(n_wr) - FW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_cnt_q   <= '0;
      out_cnt_q   <= '0;
      q_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      smp_valid_q <= 1'b0;
      smp_cand_q  <= '0;
      tok_q       <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      done_q      <= 1'b0;
      smp_valid_q <= xfer;
      if (xfer) smp_cand_q <= bus.rnd_tdata;
      tok_q[0] <= smp_valid_q;
      for (int i = 1; i < SMP_LAT; i++) begin
        tok_q[i] <= tok_q[i-1];
      end
      acc_cnt_q  <= acc_cnt_d;
      out_cnt_q  <= out_cnt_d;
      wr_ptr_q   <= wr_ptr_q + PW'(n_wr);
      rd_ptr_q   <= rd_ptr_q + PW'(pop);
      fifo_cnt_q <= fifo_cnt_d;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q   <= RUN;
            q_q       <= bus.q_cfg;
            acc_cnt_q <= '0;
            out_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end
        RUN: begin
          if (acc_cnt_q == CW'(N_COEFF)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (inflight == '0) state_q <= FLUSH;
        end
        FLUSH: begin
          if (out_cnt_q == CW'(N_COEFF)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem_q[wr_ptr_q + PW'(wr_off[i])] <= bus.smp_data[i*CAND_BITS +: CAND_BITS];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (32'(fifo_cnt_q) + 32'(n_wr) <= 32'(FIFO_DEPTH) + 32'(pop));
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.rnd_tready  = issue_ok;
  assign bus.smp_valid   = smp_valid_q;
  assign bus.smp_cand    = smp_cand_q;
  assign bus.smp_q       = q_q;
  assign bus.coef_tvalid = fifo_nempty;
  assign bus.coef_tdata  = fifo_nempty ? mem_q[rd_ptr_q] : '0;
  assign bus.coef_index  = out_cnt_q[IW-1:0];
  assign bus.coef_tlast  = (out_cnt_q == CW'(N_COEFF - 1));
endmodule

// File: tb/tb_reject_sample_ctrl.sv
// Scoreboard bench for reject_sample_ctrl with a behavioural fixed-latency sampler.
module tb_reject_sample_ctrl;
  localparam int LANES = 4, CB = 12, NC = 256, LAT = 3, FD = 16;
  localparam int LW = LANES * CB;
  localparam logic [15:0] Q = 16'd3329;

  typedef struct packed {
    logic [CB-1:0] data;
    logic [7:0]    idx;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reject_sample_ctrl_if #(.LANES(LANES), .CAND_BITS(CB), .N_COEFF(NC)) bus ();

  reject_sample_ctrl #(.LANES(LANES), .CAND_BITS(CB), .N_COEFF(NC),
                       .SMP_LAT(LAT), .FIFO_DEPTH(FD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Sampler: accepts cand < q after LAT cycles; junk on the bus when no result is due.
  logic [LAT-1:0] sv = '0;
  logic [LW-1:0]  sc [LAT];
  logic [15:0]    sq [LAT];
  logic [LANES-1:0] acc_m;
  logic [LW-1:0]    data_m;
  always @(posedge clk) begin
    sv    <= {sv[LAT-2:0], bus.smp_valid};
    sc[0] <= bus.smp_cand;
    sq[0] <= bus.smp_q;
    for (int i = 1; i < LAT; i++) begin
      sc[i] <= sc[i-1];
      sq[i] <= sq[i-1];
    end
  end
  always_comb begin
    acc_m  = '1;
    data_m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sv[LAT-1]) begin
        acc_m[i]             = (16'(sc[LAT-1][i*CB +: CB]) < sq[LAT-1]);
        data_m[i*CB +: CB]   = sc[LAT-1][i*CB +: CB];
      end else begin
        data_m[i*CB +: CB]   = 12'hABC;
      end
    end
  end
  assign bus.smp_acc  = acc_m;
  assign bus.smp_data = data_m;

  int n_cmp = 0, n_bad = 0;
  int xfer_cnt = 0, done_cnt = 0, got_cnt = 0, tready_viol = 0, exp_cnt = 0, run_done0 = 0;
  logic [CB-1:0] got_data [512];
  logic [LW-1:0] word_q [$];
  exp_t          exp_q [$];
  bit            pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  function automatic logic [LW-1:0] mk(input int a, input int b, input int c, input int d);
    return {CB'(d), CB'(c), CB'(b), CB'(a)};
  endfunction

  task automatic model_word(input logic [LW-1:0] w);
    logic [CB-1:0] c;
    exp_t e;
    for (int i = 0; i < LANES; i++) begin
      c = w[i*CB +: CB];
      if (16'(c) < Q && exp_cnt < NC) begin
        e.data = c;
        e.idx  = 8'(exp_cnt);
        e.last = (exp_cnt == NC - 1);
        exp_q.push_back(e);
        exp_cnt++;
      end
    end
  endtask

  // Driver: presents queued words; a word decided here transfers at the next posedge.
  initial begin
    bus.rnd_tvalid = 1'b0;
    bus.rnd_tdata  = '0;
    forever begin
      @(negedge clk);
      if (pend && word_q.size() > 0) begin
        model_word(word_q.pop_front());
        xfer_cnt++;
      end
      pend = 1'b0;
      if (word_q.size() > 0 && !rst) begin
        bus.rnd_tvalid = 1'b1;
        bus.rnd_tdata  = word_q[0];
      end else begin
        bus.rnd_tvalid = 1'b0;
        bus.rnd_tdata  = '0;
      end
      pend = bus.rnd_tvalid & bus.rnd_tready;
    end
  end

  // Monitor: pops the scoreboard on every accepted coefficient.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done) done_cnt++;
      if (bus.rnd_tready && !bus.busy) tready_viol++;
      if (bus.coef_tvalid && bus.coef_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL coef_unexpected: got data %0d index %0d, required no output",
                   bus.coef_tdata, bus.coef_index);
        end else begin
          e = exp_q.pop_front();
          chk("coef_data", 32'(bus.coef_tdata), 32'(e.data));
          chk("coef_index", 32'(bus.coef_index), 32'(e.idx));
          chk("coef_tlast", 32'(bus.coef_tlast), 32'(e.last));
        end
        if (got_cnt < 512) got_data[got_cnt] = bus.coef_tdata;
        got_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_valid(input int n);
    for (int k = 0; k < n; k++) word_q.push_back(mk(4*k, 4*k+1, 4*k+2, 4*k+3));
  endtask

  task automatic start_run();
    exp_cnt   = 0;
    got_cnt   = 0;
    run_done0 = done_cnt;
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    for (int c = 0; c < 5000; c++) begin
      if (done_cnt != run_done0) break;
      cyc(1);
    end
    cyc(8);
    chk({tag, "_done_pulses"}, 32'(done_cnt - run_done0), 32'd1);
    chk({tag, "_coef_count"}, 32'(got_cnt), 32'(NC));
    chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "_tready_idle"}, 32'(tready_viol), 32'd0);
    word_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int x0;
    bus.start       = 1'b0;
    bus.q_cfg       = Q;
    bus.coef_tready = 1'b1;
    cyc(3);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rnd_tready", 32'(bus.rnd_tready), 0);
    chk("rst_smp_valid", 32'(bus.smp_valid), 0);
    chk("rst_smp_cand", 32'(bus.smp_cand), 0);
    chk("rst_smp_q", 32'(bus.smp_q), 0);
    chk("rst_coef_tvalid", 32'(bus.coef_tvalid), 0);
    chk("rst_coef_tdata", 32'(bus.coef_tdata), 0);
    chk("rst_coef_index", 32'(bus.coef_index), 0);
    chk("rst_coef_tlast", 32'(bus.coef_tlast), 0);
    rst = 1'b0;
    cyc(2);

    // Full run of accept-all words, with a stray start mid-run.
    x0 = xfer_cnt;
    push_valid(64);
    start_run();
    chk("t1_busy", 32'(bus.busy), 1);
    chk("t1_smp_q", 32'(bus.smp_q), 32'(Q));
    cyc(50);
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
    finish_run("t1");
    chk("t1_issues", 32'(xfer_cnt - x0), 64);

    // All-reject words first: nothing reaches the FIFO.
    x0 = xfer_cnt;
    for (int k = 0; k < 20; k++) word_q.push_back(mk(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF));
    start_run();
    for (int c = 0; c < 1000 && (xfer_cnt - x0) < 20; c++) cyc(1);
    cyc(10);
    chk("t2_reject_issues", 32'(xfer_cnt - x0), 20);
    chk("t2_no_coef", 32'(got_cnt), 0);
    chk("t2_tvalid", 32'(bus.coef_tvalid), 0);
    chk("t2_index", 32'(bus.coef_index), 0);
    push_valid(64);
    finish_run("t2");

    // Mixed accept/reject lanes.
    word_q.push_back(mk(10, 3500, 20, 4000));
    push_valid(64);
    start_run();
    finish_run("t3");
    chk("t3_first", 32'(got_data[0]), 10);
    chk("t3_second", 32'(got_data[1]), 20);
    chk("t3_third", 32'(got_data[2]), 0);

    // Excess accepted lanes past the last coefficient are dropped.
    push_valid(63);
    word_q.push_back(mk(100, 200, 4000, 4000));
    word_q.push_back(mk(1000, 1001, 1002, 1003));
    word_q.push_back(mk(2000, 2001, 2002, 2003));
    push_valid(4);
    start_run();
    finish_run("t4");
    chk("t4_idx252", 32'(got_data[252]), 100);
    chk("t4_idx254", 32'(got_data[254]), 1000);
    chk("t4_idx255", 32'(got_data[255]), 1001);

    // Backpressure: credit stops issue at a full FIFO.
    bus.coef_tready = 1'b0;
    x0 = xfer_cnt;
    push_valid(70);
    start_run();
    cyc(40);
    chk("t5_stall_issues", 32'(xfer_cnt - x0), 4);
    chk("t5_stall_tready", 32'(bus.rnd_tready), 0);
    chk("t5_stall_tvalid", 32'(bus.coef_tvalid), 1);
    chk("t5_stall_head", 32'(bus.coef_tdata), 0);
    bus.coef_tready = 1'b1;
    finish_run("t5");

    // Reset with two words in flight, then a clean run.
    x0 = xfer_cnt;
    push_valid(2);
    start_run();
    for (int c = 0; c < 100 && (xfer_cnt - x0) < 2; c++) cyc(1);
    rst  = 1'b1;
    pend = 1'b0;
    word_q.delete();
    exp_q.delete();
    cyc(1);
    chk("t6_rst_busy", 32'(bus.busy), 0);
    chk("t6_rst_smp_valid", 32'(bus.smp_valid), 0);
    chk("t6_rst_smp_cand", 32'(bus.smp_cand), 0);
    chk("t6_rst_tvalid", 32'(bus.coef_tvalid), 0);
    chk("t6_rst_tready", 32'(bus.rnd_tready), 0);
    chk("t6_rst_index", 32'(bus.coef_index), 0);
    rst = 1'b0;
    cyc(12);
    chk("t6_no_done", 32'(done_cnt - run_done0), 0);
    chk("t6_no_stale", 32'(got_cnt), 0);
    push_valid(64);
    start_run();
    finish_run("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
